sprite_line_engine: RTL and testbench

//   Parametrised TMS9918-style sprite unit for the MSX video path. Scans the sprite attribute

---
 rtl/msx_vdp_pkg.sv | 24 ++
 rtl/sprite_slot.sv | 48 ++++
 rtl/sprite_line_engine.sv | 222 ++++++++++++++++++++++
 tb/tb_sprite_line_engine.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/msx_vdp_pkg.sv
// Shared MSX VDP definitions: sprite FSM state codes, SAT constants, palette indices.
package msx_vdp_pkg;
    typedef logic [3:0] state_t;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_RD_Y  = 4'd1;
    localparam logic [3:0] S_CHK   = 4'd2;
    localparam logic [3:0] S_RD_X  = 4'd3;
    localparam logic [3:0] S_RD_N  = 4'd4;
    localparam logic [3:0] S_RD_C  = 4'd5;
    localparam logic [3:0] S_RD_P0 = 4'd6;
    localparam logic [3:0] S_RD_P1 = 4'd7;
    localparam logic [3:0] S_NEXT  = 4'd8;
    localparam logic [3:0] S_DONE  = 4'd9;

    localparam logic [7:0] SAT_TERMINATOR  = 8'hD0;
    localparam int         EC_SHIFT        = 32;
    localparam logic [3:0] PAL_TRANSPARENT = 4'h0;

    // Sprite height/width in screen pixels: 8 or 16, doubled when magnified.
    function automatic logic [5:0] spr_extent(input logic size16, input logic mag);
        spr_extent = (size16 ? 6'd16 : 6'd8) << mag;
    endfunction
endpackage

// File: rtl/sprite_slot.sv
// One latched sprite for the current line: stores position/colour/pattern, produces a hit bit.
import msx_vdp_pkg::*;

module sprite_slot (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clr,
    input  logic              i_we,
    input  logic signed [8:0] i_x_start,
    input  logic [3:0]        i_color,
    input  logic [15:0]       i_pattern,
    input  logic [7:0]        i_pix_x,
    input  logic              i_size16,
    input  logic              i_mag,
    output logic              o_hit,
    output logic [3:0]        o_color
);
    logic              r_valid;
    logic signed [8:0] r_x_start;
    logic [3:0]        r_color;
    logic [15:0]       r_pattern;
    logic [9:0]        w_dx;
    logic [3:0]        w_bit;
    logic              w_in;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid   <= 1'b0;
            r_x_start <= '0;
            r_color   <= '0;
            r_pattern <= '0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_we) begin
            r_valid   <= 1'b1;
            r_x_start <= i_x_start;
            r_color   <= i_color;
            r_pattern <= i_pattern;
        end
    end

    // dx is 10-bit two's complement; negative means left of the sprite, no wrap.
    assign w_dx  = {2'b00, i_pix_x} - {r_x_start[8], r_x_start};
    assign w_in  = !w_dx[9] && (w_dx < {4'b0000, spr_extent(i_size16, i_mag)});
    assign w_bit = i_mag ? w_dx[4:1] : w_dx[3:0];
    assign o_hit   = r_valid && w_in && r_pattern[4'd15 - w_bit];
    assign o_color = r_color;
endmodule

// File: rtl/sprite_line_engine.sv
// TMS9918-style sprite line engine: SAT scan in hblank, per-pixel sprite colour in the active line.
// Optional collision detection with `define SPRITE_COLLISION_EN.
import msx_vdp_pkg::*;

module sprite_line_engine #(
    parameter int MAX_SPR     = 4,
    parameter int NUM_ENTRIES = 32,
    parameter int ADDR_W      = 14
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_line_start,
    input  logic [7:0]        i_next_y,
    input  logic [ADDR_W-1:0] i_sprite_attr_addr,
    input  logic [ADDR_W-1:0] i_sprite_pattern_table_addr,
    input  logic              i_size16,
    input  logic              i_mag,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    input  logic [7:0]        i_mem_data,
    output logic              o_eval_done,
    input  logic [7:0]        i_pix_x,
    input  logic              i_pix_valid,
    output logic [3:0]        o_spr_color,
    output logic              o_spr_opaque,
    output logic              o_status_5th,
    output logic [4:0]        o_status_5th_num,
    output logic              o_status_coll,
    input  logic              i_status_clr
);
    localparam int CNT_W = $clog2(MAX_SPR + 1);
    localparam int N_W   = $clog2(NUM_ENTRIES) + 1;

    state_t             r_state;
    logic [N_W-1:0]     r_n;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_y, r_x, r_name, r_p0;
    logic [4:0]         r_row;
    logic               r_ec, r_fill, r_5th;
    logic [3:0]         r_col;
    logic [4:0]         r_5th_num;
    logic [3:0]         r_spr_color;
    logic               r_spr_opaque;

    logic [7:0]         w_row;
    logic               w_online, w_store;
    logic [7:0]         w_name_m;
    logic [3:0]         w_pr;
    logic [ADDR_W-1:0]  w_ent_addr, w_pat_addr;
    logic signed [8:0]  w_x_start;
    logic [15:0]        w_pattern;
    logic [MAX_SPR-1:0] w_we, w_hit;
    logic [MAX_SPR-1:0][3:0] w_slot_col;
    logic               w_any;
    logic [3:0]         w_col;

    assign w_row    = r_y - i_mem_data - 8'd1;
    assign w_online = w_row < {2'b00, spr_extent(i_size16, i_mag)};
    assign w_name_m = i_size16 ? (r_name & 8'hFC) : r_name;
    assign w_pr     = i_mag ? r_row[4:1] : r_row[3:0];
    assign w_ent_addr = i_sprite_attr_addr + ADDR_W'({r_n, 2'b00});
    assign w_pat_addr = i_sprite_pattern_table_addr + ADDR_W'({w_name_m, 3'b000}) + ADDR_W'(w_pr);
    assign w_x_start  = $signed({1'b0, r_x}) - (r_ec ? 9'(EC_SHIFT) : 9'd0);
    // The last pattern byte lands on mem_data in NEXT; the 8-wide case leaves the right half empty.
    assign w_pattern  = i_size16 ? {r_p0, i_mem_data} : {i_mem_data, 8'h00};
    assign w_store    = (r_state == S_NEXT) && r_fill;

    always_comb begin
        o_mem_rd   = 1'b1;
        o_mem_addr = '0;
        case (r_state)
            S_RD_Y:  o_mem_addr = w_ent_addr;
            S_RD_X:  o_mem_addr = w_ent_addr + ADDR_W'(1);
            S_RD_N:  o_mem_addr = w_ent_addr + ADDR_W'(2);
            S_RD_C:  o_mem_addr = w_ent_addr + ADDR_W'(3);
            S_RD_P0: o_mem_addr = w_pat_addr;
            S_RD_P1: o_mem_addr = w_pat_addr + ADDR_W'(16);
            default: o_mem_rd   = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_n       <= '0;
            r_cnt     <= '0;
            r_y       <= '0;
            r_x       <= '0;
            r_name    <= '0;
            r_p0      <= '0;
            r_row     <= '0;
            r_ec      <= 1'b0;
            r_col     <= '0;
            r_fill    <= 1'b0;
            r_5th     <= 1'b0;
            r_5th_num <= '0;
        end else begin
            if (i_status_clr)
                r_5th <= 1'b0;
            if (i_line_start) begin
                r_state <= S_RD_Y;
                r_n     <= '0;
                r_cnt   <= '0;
                r_y     <= i_next_y;
                r_fill  <= 1'b0;
            end else begin
                case (r_state)
                    S_RD_Y: r_state <= S_CHK;
                    S_CHK: begin
                        if (i_mem_data == SAT_TERMINATOR)
                            r_state <= S_DONE;
                        else if (!w_online)
                            r_state <= S_NEXT;
                        else if (r_cnt == CNT_W'(MAX_SPR)) begin
                            // A same-cycle status_clr must not hide this overflow.
                            if (!r_5th || i_status_clr) begin
                                r_5th     <= 1'b1;
                                r_5th_num <= 5'(r_n);
                            end
                            r_state <= S_DONE;
                        end else begin
                            r_row   <= w_row[4:0];
                            r_state <= S_RD_X;
                        end
                    end
                    S_RD_X: r_state <= S_RD_N;
                    S_RD_N: begin
                        r_x     <= i_mem_data;
                        r_state <= S_RD_C;
                    end
                    S_RD_C: begin
                        r_name  <= i_mem_data;
                        r_state <= S_RD_P0;
                    end
                    S_RD_P0: begin
                        r_ec    <= i_mem_data[7];
                        r_col   <= i_mem_data[3:0];
                        r_fill  <= 1'b1;
                        r_state <= i_size16 ? S_RD_P1 : S_NEXT;
                    end
                    S_RD_P1: begin
                        r_p0    <= i_mem_data;
                        r_state <= S_NEXT;
                    end
                    S_NEXT: begin
                        if (r_fill) begin
                            r_cnt  <= r_cnt + CNT_W'(1);
                            r_fill <= 1'b0;
                        end
                        r_n     <= r_n + N_W'(1);
                        r_state <= (r_n == N_W'(NUM_ENTRIES - 1)) ? S_DONE : S_RD_Y;
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    for (genvar g = 0; g < MAX_SPR; g++) begin : g_slot
        assign w_we[g] = w_store && (r_cnt == CNT_W'(g));
        sprite_slot u_slot (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_clr     (i_line_start),
            .i_we      (w_we[g]),
            .i_x_start (w_x_start),
            .i_color   (r_col),
            .i_pattern (w_pattern),
            .i_pix_x   (i_pix_x),
            .i_size16  (i_size16),
            .i_mag     (i_mag),
            .o_hit     (w_hit[g]),
            .o_color   (w_slot_col[g])
        );
    end

    always_comb begin
        w_any = 1'b0;
        w_col = PAL_TRANSPARENT;
        for (int i = MAX_SPR - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_any = 1'b1;
                w_col = w_slot_col[i];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || !i_pix_valid) begin
            r_spr_color  <= '0;
            r_spr_opaque <= 1'b0;
        end else begin
            r_spr_color  <= w_any ? w_col : PAL_TRANSPARENT;
            r_spr_opaque <= w_any && (w_col != PAL_TRANSPARENT);
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic r_coll;
    logic w_multi;
    assign w_multi = (w_hit & (w_hit - MAX_SPR'(1))) != '0;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_coll <= 1'b0;
        else if (i_pix_valid && w_multi)
            r_coll <= 1'b1;
        else if (i_status_clr)
            r_coll <= 1'b0;
    end
    assign o_status_coll = r_coll;
`else
    assign o_status_coll = 1'b0;
`endif

    assign o_eval_done      = (r_state == S_IDLE);
    assign o_spr_color      = r_spr_color;
    assign o_spr_opaque     = r_spr_opaque;
    assign o_status_5th     = r_5th;
    assign o_status_5th_num = r_5th_num;
endmodule

// File: tb/tb_sprite_line_engine.sv
// Bench for sprite_line_engine: VRAM model, SAT-level reference model, directed and random lines.
module tb_sprite_line_engine;
    localparam int MAX_SPR = 4;
    localparam int NE      = 32;
    localparam int ATTR    = 'h1B00;
    localparam int PAT     = 'h3800;

    logic        clk = 1'b0;
    logic        reset, line_start, size16, mag, pix_valid, status_clr;
    logic [7:0]  next_y, pix_x;
    logic [7:0]  mem_data = 8'h00;
    logic [13:0] mem_addr;
    logic        mem_rd, eval_done, spr_opaque, st5, stc;
    logic [3:0]  spr_color;
    logic [4:0]  st5n;

    logic [7:0]  vram [0:16383];
    logic [13:0] rd_q [$];
    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int         m_n;
    int         m_xs  [MAX_SPR];
    logic [3:0] m_col [MAX_SPR];
    logic [15:0] m_pat[MAX_SPR];
    logic       e5 = 1'b0;
    logic [4:0] e5n = 5'd0;
    logic       ecoll = 1'b0;

    sprite_line_engine #(.MAX_SPR(MAX_SPR), .NUM_ENTRIES(NE), .ADDR_W(14)) dut (
        .i_clk(clk), .i_reset(reset), .i_line_start(line_start), .i_next_y(next_y),
        .i_sprite_attr_addr(14'(ATTR)), .i_sprite_pattern_table_addr(14'(PAT)),
        .i_size16(size16), .i_mag(mag), .o_mem_addr(mem_addr), .o_mem_rd(mem_rd),
        .i_mem_data(mem_data), .o_eval_done(eval_done), .i_pix_x(pix_x), .i_pix_valid(pix_valid),
        .o_spr_color(spr_color), .o_spr_opaque(spr_opaque), .o_status_5th(st5),
        .o_status_5th_num(st5n), .o_status_coll(stc), .i_status_clr(status_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (mem_rd) mem_data <= vram[mem_addr];
    always @(negedge clk) if (mem_rd) rd_q.push_back(mem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ext();
        return (size16 ? 16 : 8) << mag;
    endfunction

    task automatic set_ent(input int e, input logic [7:0] y, input logic [7:0] x,
                           input logic [7:0] nm, input logic [7:0] c);
        vram[ATTR + 4*e]     = y;
        vram[ATTR + 4*e + 1] = x;
        vram[ATTR + 4*e + 2] = nm;
        vram[ATTR + 4*e + 3] = c;
    endtask

    // Walk the SAT the way the VDP rules describe and collect the visible sprites.
    task automatic build_model();
        int y, row, nm, c, base;
        m_n = 0;
        for (int e = 0; e < NE; e++) begin
            y = int'(vram[ATTR + 4*e]);
            if (y == 'hD0) break;
            row = (int'(next_y) - y - 1) & 255;
            if (row >= ext()) continue;
            if (m_n == MAX_SPR) begin
                if (!e5) begin e5 = 1'b1; e5n = 5'(e); end
                break;
            end
            nm = int'(vram[ATTR + 4*e + 2]);
            c  = int'(vram[ATTR + 4*e + 3]);
            if (size16) nm = nm & 'hFC;
            base = (PAT + nm*8 + (row >> mag)) & 'h3FFF;
            m_xs[m_n]  = int'(vram[ATTR + 4*e + 1]) - (((c >> 7) & 1) != 0 ? 32 : 0);
            m_col[m_n] = 4'(c & 15);
            m_pat[m_n] = size16 ? {vram[base], vram[(base + 16) & 'h3FFF]} : {vram[base], 8'h00};
            m_n++;
        end
    endtask

    task automatic ref_pix(input int x, output logic [3:0] c, output logic op, output int nh);
        int dx;
        c = 4'h0; op = 1'b0; nh = 0;
        for (int s = 0; s < m_n; s++) begin
            dx = x - m_xs[s];
            if (dx >= 0 && dx < ext() && m_pat[s][15 - (dx >> mag)]) begin
                if (nh == 0) begin c = m_col[s]; op = (m_col[s] != 4'h0); end
                nh++;
            end
        end
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (eval_done !== 1'b1 && t < 400) begin @(negedge clk); t++; end
        chk(tag, 32'(eval_done), 32'd1);
    endtask

    task automatic scan(input string tag);
        rd_q.delete();
        @(negedge clk); line_start = 1'b1;
        @(negedge clk); line_start = 1'b0;
        wait_done(tag);
        build_model();
        chk("st5", 32'(st5), 32'(e5));
        chk("st5n", 32'(st5n), 32'(e5n));
    endtask

    task automatic clr_status();
        @(negedge clk); status_clr = 1'b1;
        @(negedge clk); status_clr = 1'b0;
        e5 = 1'b0; ecoll = 1'b0;
        chk("clr_5th", 32'(st5), 32'd0);
        chk("clr_coll", 32'(stc), 32'd0);
    endtask

    task automatic sweep(input string tag);
        logic [3:0] pc;
        logic pop, pv;
        int nh;
        pc = 4'h0; pop = 1'b0; pv = 1'b0;
        for (int x = 0; x <= 256; x++) begin
            @(negedge clk);
            if (x > 0) chk(tag, {27'd0, spr_color, spr_opaque}, pv ? {27'd0, pc, pop} : 32'd0);
            if (x < 256) begin
                pv = ($urandom_range(0, 9) != 0);
                pix_x = 8'(x); pix_valid = pv;
                ref_pix(x, pc, pop, nh);
`ifdef SPRITE_COLLISION_EN
                if (pv && nh >= 2) ecoll = 1'b1;
`endif
            end else pix_valid = 1'b0;
        end
        chk("coll", 32'(stc), 32'(ecoll));
    endtask

    task automatic chk_px(input string tag, input int x, input logic [3:0] ec, input logic eo);
        @(negedge clk); pix_x = 8'(x); pix_valid = 1'b1;
        @(negedge clk); pix_valid = 1'b0;
        chk(tag, {27'd0, spr_color, spr_opaque}, {27'd0, ec, eo});
    endtask

    task automatic find_rd(input string tag, input int addr);
        logic f;
        f = 1'b0;
        foreach (rd_q[i]) if (rd_q[i] == 14'(addr)) f = 1'b1;
        chk(tag, 32'(f), 32'd1);
    endtask

    initial begin
        logic hit;
        for (int i = 0; i < 16384; i++) vram[i] = 8'($urandom);
        reset = 1'b1; line_start = 1'b0; next_y = 8'd0; size16 = 1'b0; mag = 1'b0;
        pix_x = 8'd0; pix_valid = 1'b0; status_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_rd", 32'(mem_rd), 32'd0);
        chk("rst_done", 32'(eval_done), 32'd1);
        chk("rst_pix", {27'd0, spr_color, spr_opaque}, 32'd0);
        chk("rst_stat", {25'd0, st5, st5n, stc}, 32'd0);
        reset = 1'b0;

        // single 8x8 sprite, one lit pixel
        set_ent(0, 8'd9, 8'd20, 8'd1, 8'd15); set_ent(1, 8'hD0, 0, 0, 0);
        vram[PAT + 9] = 8'h80; next_y = 8'd11;
        scan("t1_done");
        chk_px("t1_x20", 20, 4'd15, 1'b1);
        chk_px("t1_x21", 21, 4'd0, 1'b0);
        sweep("t1_pix");

        // fifth sprite, then clear, then clear coinciding with the set
        for (int e = 0; e < 5; e++) set_ent(e, 8'd0, 8'(40*e), 8'(e), 8'(e + 2));
        set_ent(5, 8'hD0, 0, 0, 0); next_y = 8'd1;
        scan("t2_done");
        chk("t2_5th", 32'(st5), 32'd1);
        chk("t2_num", 32'(st5n), 32'd4);
        sweep("t2_pix");
        clr_status();
        @(negedge clk); line_start = 1'b1;
        @(negedge clk); line_start = 1'b0;
        hit = 1'b0;
        for (int t = 0; t < 400 && !hit; t++) begin
            if (mem_rd && mem_addr == 14'(ATTR + 16)) hit = 1'b1;
            else @(negedge clk);
        end
        chk("t2_seen_e4", 32'(hit), 32'd1);
        @(negedge clk); status_clr = 1'b1;
        @(negedge clk); status_clr = 1'b0;
        wait_done("t2b_done");
        chk("t2b_5th", 32'(st5), 32'd1);
        chk("t2b_num", 32'(st5n), 32'd4);
        clr_status();

        // terminator in entry 0
        set_ent(0, 8'hD0, 8'd30, 8'd2, 8'd7); set_ent(1, 8'd20, 8'd30, 8'd2, 8'd7);
        next_y = 8'd22;
        scan("t3_done");
        chk("t3_nrd", 32'(rd_q.size()), 32'd1);
        if (rd_q.size() > 0) chk("t3_addr", 32'(rd_q[0]), 32'(ATTR));
        chk("t3_nslot", 32'(m_n), 32'd0);
        sweep("t3_pix");

        // 16x16 magnified, name 5 masked to 4
        size16 = 1'b1; mag = 1'b1;
        set_ent(0, 8'd39, 8'd100, 8'd5, 8'd6); set_ent(1, 8'hD0, 0, 0, 0);
        next_y = 8'd50; vram[PAT + 37] = 8'hFF; vram[PAT + 53] = 8'hFF;
        scan("t4_done");
        find_rd("t4_p0", PAT + 37);
        find_rd("t4_p1", PAT + 53);
        chk_px("t4_x99", 99, 4'd0, 1'b0);
        chk_px("t4_x100", 100, 4'd6, 1'b1);
        chk_px("t4_x131", 131, 4'd6, 1'b1);
        chk_px("t4_x132", 132, 4'd0, 1'b0);
        vram[PAT + 37] = 8'hA5; vram[PAT + 53] = 8'h3C;
        scan("t4b_done");
        sweep("t4b_pix");

        // early clock clipping on the left
        set_ent(0, 8'd60, 8'd10, 8'd8, 8'h87); next_y = 8'd61;
        vram[PAT + 64] = 8'h00; vram[PAT + 80] = 8'h1F;
        scan("t5_done");
        chk_px("t5_x0", 0, 4'd7, 1'b1);
        chk_px("t5_x9", 9, 4'd7, 1'b1);
        chk_px("t5_x10", 10, 4'd0, 1'b0);
        sweep("t5_pix");

        // overlapping sprites
        size16 = 1'b0; mag = 1'b0;
        set_ent(0, 8'd70, 8'd50, 8'd9, 8'd3); set_ent(1, 8'd70, 8'd54, 8'd9, 8'd4);
        set_ent(2, 8'hD0, 0, 0, 0); vram[PAT + 72] = 8'hFF; next_y = 8'd71;
        scan("t6_done");
        sweep("t6_pix");
        clr_status();

        // random lines
        for (int l = 0; l < 8; l++) begin
            logic [7:0] y;
            next_y = 8'($urandom_range(0, 191));
            size16 = 1'($urandom); mag = 1'($urandom);
            for (int e = 0; e < NE; e++) begin
                y = 8'(int'(next_y) - 1 - int'($urandom_range(0, 70)));
                if ($urandom_range(0, 39) == 0) y = 8'hD0;
                set_ent(e, y, 8'($urandom), 8'($urandom), 8'($urandom));
            end
            for (int i = PAT; i < PAT + 2048; i++) vram[i] = 8'($urandom);
            clr_status();
            scan("rnd_done");
            sweep("rnd_pix");
        end

        // reset in the middle of a scan
        for (int e = 0; e < NE; e++) set_ent(e, 8'(int'(next_y) - 1), 8'($urandom), 8'd0, 8'd5);
        @(negedge clk); line_start = 1'b1;
        @(negedge clk); line_start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_rd", 32'(mem_rd), 32'd0);
        chk("mid_rst_done", 32'(eval_done), 32'd1);
        @(negedge clk);
        chk("mid_rst_rd2", 32'(mem_rd), 32'd0);
        chk("mid_rst_stat", {25'd0, st5, st5n, stc}, 32'd0);
        reset = 1'b0;
        e5 = 1'b0; e5n = 5'd0; ecoll = 1'b0; m_n = 0;
        sweep("post_rst_pix");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
